// File: rtl/decoy_capture_pkg.sv
// Shared defaults and FSM encoding for the decoy capture path.
package decoy_capture_pkg;

  localparam int unsigned WORD_W_DEF   = 32;
  localparam int unsigned CNT_W_DEF    = 32;
  localparam int unsigned PPS_SYNC_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } cap_state_e;

endpackage

// File: rtl/pps_edge_sync.sv
// PPS synchroniser and rising-edge detector; registered one-cycle pulse
// SYNC_STAGES+1 cycles after the raw pin edge.
module pps_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pps_i,
  output logic pps_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      pps_rise <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pps_i};
      prev_q   <= sync_q[SYNC_STAGES-1];
      pps_rise <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/decoy_capture.sv
// Receive-side decoy capture: PPS-aligned bit packing into words, a 2-entry
// output skid FIFO and per-PPS-period slot statistics.
module decoy_capture
  import decoy_capture_pkg::*;
#(
  parameter int unsigned WORD_W   = WORD_W_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned PPS_SYNC = PPS_SYNC_DEF
) (
  input  logic              clk240,
  input  logic              rst_240_n,
  input  logic              pps_i,
  input  logic              pps_trigger,
  input  logic              slot_en,
  input  logic              decoy_in,
  input  logic              overflow_clr,
  output logic [WORD_W-1:0] word_data,
  output logic              word_first,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [CNT_W-1:0]  slots_count,
  output logic [CNT_W-1:0]  ones_count,
  output logic              stats_valid,
  output logic              overflow
);

  localparam int unsigned BIT_CNT_W = $clog2(WORD_W);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_W - 1);

  cap_state_e state_q, state_d;
  logic pps_rise;

  logic [WORD_W-2:0]    shift_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic                 first_flag_q;
  logic [CNT_W-1:0]     slot_cnt_q, ones_cnt_q;

  logic [WORD_W-1:0] tail_data_q;
  logic              tail_first_q, tail_valid_q;

  logic              run, start, period_end, slot, push, pop, drop;
  logic [WORD_W-1:0] push_data;

  pps_edge_sync #(
    .SYNC_STAGES(PPS_SYNC)
  ) u_pps_sync (
    .clk     (clk240),
    .rst_n   (rst_240_n),
    .pps_i   (pps_i),
    .pps_rise(pps_rise)
  );

  // Next state and datapath control strobes.
  always_comb begin
    state_d    = state_q;
    run        = (state_q == ST_RUN) & pps_trigger;
    start      = (state_q == ST_ARMED) & pps_trigger & pps_rise;
    period_end = run & pps_rise;
    slot       = run & slot_en;
    push       = slot & ~pps_rise & (bit_cnt_q == LAST_BIT);
    push_data  = {shift_q, decoy_in};
    pop        = word_valid & word_ready;
    drop       = push & word_valid & tail_valid_q & ~pop;

    if (!pps_trigger) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_ARMED;
        ST_ARMED: if (pps_rise) state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk240 or negedge rst_240_n) begin
    if (!rst_240_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Shift register, bit counter and period counters; a slot coincident with
  // a PPS edge opens the new period.
  always_ff @(posedge clk240 or negedge rst_240_n) begin
    if (!rst_240_n) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      first_flag_q <= 1'b0;
      slot_cnt_q   <= '0;
      ones_cnt_q   <= '0;
    end else if (start) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      first_flag_q <= 1'b1;
      slot_cnt_q   <= '0;
      ones_cnt_q   <= '0;
    end else if (period_end) begin
      first_flag_q <= 1'b1;
      if (slot_en) begin
        shift_q    <= (WORD_W-1)'(decoy_in);
        bit_cnt_q  <= BIT_CNT_W'(1);
        slot_cnt_q <= CNT_W'(1);
        ones_cnt_q <= CNT_W'(decoy_in);
      end else begin
        shift_q    <= '0;
        bit_cnt_q  <= '0;
        slot_cnt_q <= '0;
        ones_cnt_q <= '0;
      end
    end else if (slot) begin
      shift_q   <= {shift_q[WORD_W-3:0], decoy_in};
      bit_cnt_q <= push ? '0 : bit_cnt_q + BIT_CNT_W'(1);
      if (push) first_flag_q <= 1'b0;
      if (slot_cnt_q != '1) slot_cnt_q <= slot_cnt_q + CNT_W'(1);
      if (decoy_in && (ones_cnt_q != '1)) ones_cnt_q <= ones_cnt_q + CNT_W'(1);
    end else if (!pps_trigger) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end
  end

  // Statistics snapshot at each PPS edge while running.
  always_ff @(posedge clk240 or negedge rst_240_n) begin
    if (!rst_240_n) begin
      slots_count <= '0;
      ones_count  <= '0;
      stats_valid <= 1'b0;
    end else begin
      stats_valid <= period_end;
      if (period_end) begin
        slots_count <= slot_cnt_q;
        ones_count  <= ones_cnt_q;
      end
    end
  end

  // 2-entry skid FIFO: head drives the outputs directly, tail absorbs one stall.
  always_ff @(posedge clk240 or negedge rst_240_n) begin
    if (!rst_240_n) begin
      word_data    <= '0;
      word_first   <= 1'b0;
      word_valid   <= 1'b0;
      tail_data_q  <= '0;
      tail_first_q <= 1'b0;
      tail_valid_q <= 1'b0;
    end else if (!pps_trigger) begin
      word_valid   <= 1'b0;
      tail_valid_q <= 1'b0;
    end else if (pop) begin
      if (tail_valid_q) begin
        word_data  <= tail_data_q;
        word_first <= tail_first_q;
        if (push) begin
          tail_data_q  <= push_data;
          tail_first_q <= first_flag_q;
        end else begin
          tail_valid_q <= 1'b0;
        end
      end else if (push) begin
        word_data  <= push_data;
        word_first <= first_flag_q;
      end else begin
        word_valid <= 1'b0;
      end
    end else if (push) begin
      if (!word_valid) begin
        word_data  <= push_data;
        word_first <= first_flag_q;
        word_valid <= 1'b1;
      end else if (!tail_valid_q) begin
        tail_data_q  <= push_data;
        tail_first_q <= first_flag_q;
        tail_valid_q <= 1'b1;
      end
    end
  end

  // Sticky drop flag; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk240 or negedge rst_240_n) begin
    if (!rst_240_n)        overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_decoy_capture.sv
// Directed bench for decoy_capture: arming, back-pressure, PPS handling,
// disarm and asynchronous reset.
module tb_decoy_capture;

  logic        clk240;
  logic        rst_240_n;
  logic        pps_i;
  logic        pps_trigger;
  logic        slot_en;
  logic        decoy_in;
  logic        overflow_clr;
  logic [31:0] word_data;
  logic        word_first;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] slots_count;
  logic [31:0] ones_count;
  logic        stats_valid;
  logic        overflow;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  decoy_capture dut (
    .clk240      (clk240),
    .rst_240_n   (rst_240_n),
    .pps_i       (pps_i),
    .pps_trigger (pps_trigger),
    .slot_en     (slot_en),
    .decoy_in    (decoy_in),
    .overflow_clr(overflow_clr),
    .word_data   (word_data),
    .word_first  (word_first),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .slots_count (slots_count),
    .ones_count  (ones_count),
    .stats_valid (stats_valid),
    .overflow    (overflow)
  );

  initial clk240 = 1'b0;
  always #2 clk240 = ~clk240;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk240);
    #1;
  endtask

  task automatic slot(input logic d);
    slot_en  = 1'b1;
    decoy_in = d;
    tick();
    slot_en  = 1'b0;
    tick();
  endtask

  // Sends n slots taken MSB-first from pat.
  task automatic slots(input logic [31:0] pat, input int n);
    for (int i = 0; i < n; i++) slot(pat[31-i]);
  endtask

  // Raw PPS edge; the optional slot lands in the cycle pps_rise is high.
  task automatic pps_edge(input logic with_slot, input logic d);
    pps_i = 1'b1;
    repeat (3) tick();
    slot_en  = with_slot;
    decoy_in = d;
    tick();
    slot_en = 1'b0;
    pps_i   = 1'b0;
  endtask

  task automatic take_word(input string tag, input logic [31:0] exp_data, input logic exp_first);
    check({tag, ".valid"}, 64'(word_valid), 64'd1);
    check({tag, ".data"},  64'(word_data),  64'(exp_data));
    check({tag, ".first"}, 64'(word_first), 64'(exp_first));
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  initial begin
    rst_240_n    = 1'b0;
    pps_i        = 1'b0;
    pps_trigger  = 1'b0;
    slot_en      = 1'b0;
    decoy_in     = 1'b0;
    overflow_clr = 1'b0;
    word_ready   = 1'b0;
    repeat (3) tick();

    check("rst.valid", 64'(word_valid), 64'd0);
    check("rst.data", 64'(word_data), 64'd0);
    check("rst.first", 64'(word_first), 64'd0);
    check("rst.slots", 64'(slots_count), 64'd0);
    check("rst.stats_valid", 64'(stats_valid), 64'd0);
    check("rst.overflow", 64'(overflow), 64'd0);
    check("rst.state", 64'(dut.state_q), 64'd0);
    rst_240_n = 1'b1;
    tick();

    // Arming: slots before the PPS edge are ignored.
    pps_trigger = 1'b1;
    tick();
    check("arm.state", 64'(dut.state_q), 64'd1);
    slots(32'hFFFF_FFFF, 5);
    check("arm.no_word", 64'(word_valid), 64'd0);
    pps_edge(1'b0, 1'b0);
    check("arm.state_run", 64'(dut.state_q), 64'd2);
    check("arm.no_stats", 64'(stats_valid), 64'd0);
    slots(32'hAAAA_AAAA, 31);
    check("arm.partial", 64'(word_valid), 64'd0);
    slot(1'b0);
    check("arm.w0.valid", 64'(word_valid), 64'd1);
    check("arm.w0.data", 64'(word_data), 64'hAAAA_AAAA);
    check("arm.w0.first", 64'(word_first), 64'd1);

    // Back-pressure: two held, third dropped.
    slots(32'hAAAA_AAAA, 32);
    check("bp.ovf_before", 64'(overflow), 64'd0);
    check("bp.hold_data", 64'(word_data), 64'hAAAA_AAAA);
    slots(32'hAAAA_AAAA, 32);
    check("bp.ovf_set", 64'(overflow), 64'd1);
    take_word("bp.w1", 32'hAAAA_AAAA, 1'b1);
    take_word("bp.w2", 32'hAAAA_AAAA, 1'b0);
    check("bp.empty", 64'(word_valid), 64'd0);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("bp.ovf_clr", 64'(overflow), 64'd0);

    // PPS mid-word: 96 + 10 slots, 48 + 5 ones since the arming edge.
    slots(32'hAAAA_AAAA, 10);
    pps_edge(1'b0, 1'b0);
    check("mid.stats_valid", 64'(stats_valid), 64'd1);
    check("mid.slots", 64'(slots_count), 64'd106);
    check("mid.ones", 64'(ones_count), 64'd53);
    check("mid.no_partial", 64'(word_valid), 64'd0);
    tick();
    check("mid.stats_pulse", 64'(stats_valid), 64'd0);
    slots(32'hCCCC_CCCC, 32);
    take_word("mid.w", 32'hCCCC_CCCC, 1'b1);

    // Coincident slot belongs to the new period.
    slots(32'hFFFF_FFFF, 5);
    pps_edge(1'b1, 1'b1);
    check("coin.slots", 64'(slots_count), 64'd37);
    check("coin.ones", 64'(ones_count), 64'd21);
    slots(32'h0000_0000, 31);
    take_word("coin.w", 32'h8000_0000, 1'b1);
    pps_edge(1'b0, 1'b0);
    check("coin.new_slots", 64'(slots_count), 64'd32);
    check("coin.new_ones", 64'(ones_count), 64'd1);

    // Disarm with one word buffered, then re-arm on a fresh PPS.
    slots(32'hFFFF_FFFF, 32);
    check("dis.buffered", 64'(word_valid), 64'd1);
    pps_trigger = 1'b0;
    tick();
    check("dis.valid", 64'(word_valid), 64'd0);
    check("dis.state", 64'(dut.state_q), 64'd0);
    pps_trigger = 1'b1;
    tick();
    slots(32'hFFFF_FFFF, 32);
    check("rearm.no_word", 64'(word_valid), 64'd0);
    pps_edge(1'b0, 1'b0);
    check("rearm.no_stats", 64'(stats_valid), 64'd0);
    slots(32'h1234_5678, 32);
    take_word("rearm.w", 32'h1234_5678, 1'b1);

    // Asynchronous reset mid-run with the FIFO full and overflow set.
    slots(32'hF0F0_F0F0, 32);
    slots(32'hF0F0_F0F0, 32);
    slots(32'hF0F0_F0F0, 32);
    check("rrun.ovf", 64'(overflow), 64'd1);
    slots(32'hF0F0_F0F0, 7);
    rst_240_n = 1'b0;
    #1;
    check("rrun.valid", 64'(word_valid), 64'd0);
    check("rrun.data", 64'(word_data), 64'd0);
    check("rrun.ovf_clr", 64'(overflow), 64'd0);
    check("rrun.slots", 64'(slots_count), 64'd0);
    check("rrun.ones", 64'(ones_count), 64'd0);
    check("rrun.state", 64'(dut.state_q), 64'd0);
    tick();
    rst_240_n = 1'b1;
    tick();
    slots(32'hFFFF_FFFF, 32);
    check("rrun.no_word", 64'(word_valid), 64'd0);
    pps_edge(1'b0, 1'b0);
    slots(32'hDEAD_BEEF, 32);
    take_word("rrun.w", 32'hDEAD_BEEF, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
